// File: rtl/int_op_eval_unit.sv
// int_op_eval_unit
//   Sequential integer operator evaluator. Accepts one (opcode, a, b) request at a
//   time over a valid/ready handshake and returns a WIDTH-bit result plus an error
//   flag over a valid/ready response. Results match constant folding bit for bit.
//   DIV/MOD run a restoring divider on |a|,|b| (one quotient bit per cycle) followed
//   by a sign-fix cycle; every other opcode completes in the cycle of acceptance.
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous reset, active low
//   req_valid_i   request valid
//   req_ready_o   request ready (high only in IDLE)
//   req_op_i      opcode: 0 ADD,1 SUB,2 EQ,3 NE,4 GE,5 GT,6 LE,7 LT,8 LNOT,9 BNOT,
//                 10 MUL,11 DIV,12 MOD,13 SHL,14 ASHL,15 SHR,16 ASHR; 17..31 illegal
//   req_a_i       operand a
//   req_b_i       operand b (unsigned shift amount for shifts)
//   resp_valid_o  response valid
//   resp_ready_i  response ready
//   resp_data_o   result
//   resp_err_o    divide/mod by zero or illegal opcode
module int_op_eval_unit #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [4:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] resp_data_o,
  output logic             resp_err_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_EQ   = 5'd2,  OP_NE   = 5'd3,
    OP_GE   = 5'd4,  OP_GT   = 5'd5,  OP_LE   = 5'd6,  OP_LT   = 5'd7,
    OP_LNOT = 5'd8,  OP_BNOT = 5'd9,  OP_MUL  = 5'd10, OP_DIV  = 5'd11,
    OP_MOD  = 5'd12, OP_SHL  = 5'd13, OP_ASHL = 5'd14, OP_SHR  = 5'd15,
    OP_ASHR = 5'd16
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX,
    S_RESP
  } state_e;

  state_e           state_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             resp_err_q;

  // Divider state: remainder, dividend/quotient shift register, divisor.
  logic [WIDTH-1:0] dv_rem_q, dv_quo_q, dv_div_q;
  logic [CW-1:0]    dv_cnt_q;
  logic             dv_qneg_q, dv_rneg_q, dv_mod_q;

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;

  function automatic logic [WIDTH-1:0] zext(input logic v);
    logic [WIDTH-1:0] r;
    r    = '0;
    r[0] = v;
    return r;
  endfunction

  // Single-cycle result, computed straight from the request inputs at accept.
  logic [WIDTH-1:0] alu_data_d;
  logic             alu_err_d;
  logic             a_lt_b, a_eq_b, sh_big, a_sign;

  always_comb begin
    alu_data_d = '0;
    alu_err_d  = 1'b0;
    a_eq_b     = (req_a_i == req_b_i);
    a_lt_b     = SIGNED ? ($signed(req_a_i) < $signed(req_b_i)) : (req_a_i < req_b_i);
    sh_big     = (req_b_i >= WIDTH);
    a_sign     = SIGNED && req_a_i[WIDTH-1];
    case (req_op_i)
      OP_ADD:  alu_data_d = req_a_i + req_b_i;
      OP_SUB:  alu_data_d = req_a_i - req_b_i;
      OP_EQ:   alu_data_d = zext(a_eq_b);
      OP_NE:   alu_data_d = zext(!a_eq_b);
      OP_GE:   alu_data_d = zext(!a_lt_b);
      OP_GT:   alu_data_d = zext(!a_lt_b && !a_eq_b);
      OP_LE:   alu_data_d = zext(a_lt_b || a_eq_b);
      OP_LT:   alu_data_d = zext(a_lt_b);
      OP_LNOT: alu_data_d = zext(req_a_i == '0);
      OP_BNOT: alu_data_d = ~req_a_i;
      OP_MUL:  alu_data_d = req_a_i * req_b_i;
      // Only reached here with b == 0; nonzero divisors go through the divider.
      OP_DIV, OP_MOD: alu_err_d = 1'b1;
      OP_SHL, OP_ASHL: alu_data_d = sh_big ? '0 : (req_a_i << req_b_i);
      OP_SHR:  alu_data_d = sh_big ? '0 : (req_a_i >> req_b_i);
      // Sign fill done as ~(~a >> b) so no signed shift is needed.
      OP_ASHR: begin
        if (sh_big)      alu_data_d = {WIDTH{a_sign}};
        else if (a_sign) alu_data_d = ~((~req_a_i) >> req_b_i);
        else             alu_data_d = req_a_i >> req_b_i;
      end
      default: alu_err_d = 1'b1;
    endcase
  end

  // One restoring-division step.
  logic [WIDTH:0]   dv_rem_sh;
  logic             dv_ge;
  logic [WIDTH-1:0] dv_rem_d, dv_quo_d;

  always_comb begin
    dv_rem_sh = {dv_rem_q, dv_quo_q[WIDTH-1]};
    dv_ge     = (dv_rem_sh >= {1'b0, dv_div_q});
    // When dv_ge the difference is below the divisor, so WIDTH bits suffice.
    dv_rem_d  = dv_ge ? (dv_rem_sh[WIDTH-1:0] - dv_div_q) : dv_rem_sh[WIDTH-1:0];
    dv_quo_d  = {dv_quo_q[WIDTH-2:0], dv_ge};
  end

  logic             b_sign, is_div_op;
  logic [WIDTH-1:0] abs_a, abs_b;

  always_comb begin
    b_sign    = SIGNED && req_b_i[WIDTH-1];
    abs_a     = a_sign ? (-req_a_i) : req_a_i;
    abs_b     = b_sign ? (-req_b_i) : req_b_i;
    is_div_op = (req_op_i == OP_DIV) || (req_op_i == OP_MOD);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      dv_rem_q     <= '0;
      dv_quo_q     <= '0;
      dv_div_q     <= '0;
      dv_cnt_q     <= '0;
      dv_qneg_q    <= 1'b0;
      dv_rneg_q    <= 1'b0;
      dv_mod_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            req_ready_q <= 1'b0;
            if (is_div_op && (req_b_i != '0)) begin
              state_q   <= S_DIV;
              dv_rem_q  <= '0;
              dv_quo_q  <= abs_a;
              dv_div_q  <= abs_b;
              dv_cnt_q  <= '0;
              dv_qneg_q <= a_sign ^ b_sign;
              dv_rneg_q <= a_sign;
              dv_mod_q  <= (req_op_i == OP_MOD);
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= alu_data_d;
              resp_err_q   <= alu_err_d;
            end
          end
        end
        S_DIV: begin
          dv_rem_q <= dv_rem_d;
          dv_quo_q <= dv_quo_d;
          dv_cnt_q <= dv_cnt_q + 1'b1;
          if (dv_cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          // Quotient truncates toward zero; remainder takes the sign of a.
          if (dv_mod_q) resp_data_q <= dv_rneg_q ? (-dv_rem_q) : dv_rem_q;
          else          resp_data_q <= dv_qneg_q ? (-dv_quo_q) : dv_quo_q;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_op_eval_unit.sv
// tb_int_op_eval_unit
//   Directed vectors for int_op_eval_unit (WIDTH=32, SIGNED=1). The driver pushes
//   the expected (data, err, latency) into a queue; the monitor pops on each
//   response handshake and compares, also checking hold-stability under backpressure.
module tb_int_op_eval_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  int_op_eval_unit #(.WIDTH(32), .SIGNED(1'b1)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_data_o (resp_data),
    .resp_err_o  (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          seen = 0;
  logic [31:0] first_data;
  logic        first_err;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency at first sight of valid, stability while held, compare at handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      if (!seen) begin
        seen       = 1;
        first_data = resp_data;
        first_err  = resp_err;
        if (exp_q.size() == 0) chk("unexpected response", 32'(exp_q.size()), 32'd1);
        else chk({exp_q[0].name, " latency"}, 32'(cyc - acc_cyc), 32'(exp_q[0].lat));
      end else begin
        chk("held data", resp_data, first_data);
        chk("held err", 32'(resp_err), 32'(first_err));
        chk("req_ready low while held", 32'(req_ready), 32'd0);
      end
      if (resp_ready) begin
        seen = 0;
        if (exp_q.size() != 0) begin
          chk({exp_q[0].name, " data"}, resp_data, exp_q[0].data);
          chk({exp_q[0].name, " err"}, 32'(resp_err), 32'(exp_q[0].err));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic ee, input int lat, input string name);
    exp_t e;
    int   n;
    e.data = ed; e.err = ee; e.lat = lat; e.name = name;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk({name, " accept timeout"}, 32'(n), 32'd0);
      req_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      acc_cyc = cyc;
      @(negedge clk);
      // Scramble request inputs after accept; captured operands must be used.
      req_valid = 1'b0; req_op = 5'(op + 5'd3); req_a = $urandom; req_b = $urandom;
    end
  endtask

  localparam logic [31:0] IMIN = 32'h8000_0000;

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;

    issue(5'd0,  32'd42, 32'd19, 32'd61, 1'b0, 1, "ADD");
    issue(5'd1,  32'd42, 32'd19, 32'd23, 1'b0, 1, "SUB");
    issue(5'd10, 32'd42, 32'd19, 32'd798, 1'b0, 1, "MUL");
    issue(5'd11, 32'd42, 32'd19, 32'd2, 1'b0, 34, "DIV");
    issue(5'd12, 32'd42, 32'd19, 32'd4, 1'b0, 34, "MOD");
    issue(5'd2,  32'd42, 32'd19, 32'd0, 1'b0, 1, "EQ");
    issue(5'd3,  32'd42, 32'd19, 32'd1, 1'b0, 1, "NE");
    issue(5'd4,  32'd42, 32'd19, 32'd1, 1'b0, 1, "GE");
    issue(5'd5,  32'd42, 32'd19, 32'd1, 1'b0, 1, "GT");
    issue(5'd6,  32'd42, 32'd19, 32'd0, 1'b0, 1, "LE");
    issue(5'd7,  32'd42, 32'd19, 32'd0, 1'b0, 1, "LT");
    issue(5'd8,  32'd42, 32'd19, 32'd0, 1'b0, 1, "LNOT");
    issue(5'd9,  32'd42, 32'd19, 32'hFFFF_FFD5, 1'b0, 1, "BNOT");
    issue(5'd13, 32'd42, 32'd19, 32'd22020096, 1'b0, 1, "SHL");
    issue(5'd14, 32'd42, 32'd19, 32'd22020096, 1'b0, 1, "ASHL");
    issue(5'd15, 32'd42, 32'd19, 32'd0, 1'b0, 1, "SHR");
    issue(5'd16, 32'd42, 32'd19, 32'd0, 1'b0, 1, "ASHR pos");
    issue(5'd16, 32'hFFFF_FFF8, 32'd1, 32'hFFFF_FFFC, 1'b0, 1, "ASHR -8>>>1");
    issue(5'd16, 32'hFFFF_FFF8, 32'd40, 32'hFFFF_FFFF, 1'b0, 1, "ASHR b=40");
    issue(5'd15, 32'hFFFF_FFF8, 32'd1, 32'h7FFF_FFFC, 1'b0, 1, "SHR -8>>1");
    issue(5'd13, 32'd1, 32'd32, 32'd0, 1'b0, 1, "SHL b=32");
    issue(5'd8,  32'd0, 32'd5, 32'd1, 1'b0, 1, "LNOT 0");
    issue(5'd7,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, "LT signed");
    issue(5'd0,  32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1, "ADD wrap");
    issue(5'd11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34, "DIV -7/2");
    issue(5'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34, "MOD -7%2");
    issue(5'd11, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34, "DIV 7/-2");
    issue(5'd12, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 34, "MOD 7%-2");
    issue(5'd11, IMIN, 32'hFFFF_FFFF, IMIN, 1'b0, 34, "DIV INT_MIN/-1");
    issue(5'd12, IMIN, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, "MOD INT_MIN%-1");
    issue(5'd11, 32'd5, 32'd0, 32'd0, 1'b1, 1, "DIV 5/0");
    issue(5'd12, 32'd5, 32'd0, 32'd0, 1'b1, 1, "MOD 5%0");
    issue(5'd17, 32'd5, 32'd3, 32'd0, 1'b1, 1, "illegal 17");
    issue(5'd31, 32'd5, 32'd3, 32'd0, 1'b1, 1, "illegal 31");

    // Backpressure: hold the response for 5 cycles.
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    resp_ready = 1'b0;
    issue(5'd1, 32'd100, 32'd1, 32'd99, 1'b0, 1, "SUB backpressure");
    n = 0;
    while (resp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("backpressure valid timeout", 32'(n), 32'd0);
    repeat (5) @(negedge clk);
    resp_ready = 1'b1;

    // Reset 10 cycles into a division: op dropped, outputs back to reset values.
    issue(5'd11, 32'd1000, 32'd7, 32'd142, 1'b0, 34, "DIV aborted");
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    seen = 0;
    chk("mid-DIV reset req_ready", 32'(req_ready), 32'd1);
    chk("mid-DIV reset resp_valid", 32'(resp_valid), 32'd0);
    chk("mid-DIV reset resp_data", resp_data, 32'd0);
    chk("mid-DIV reset resp_err", 32'(resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(5'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1, "ADD after reset");

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    chk("responses outstanding at end", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
